// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and default widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;

endpackage

// File: rtl/pipe_stage_entry.sv
// One storage slot of the pipeline stage: control + payload + valid flag.
module pipe_stage_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              vld,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    logic              vld_q,  vld_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Clearing only drops the valid flag; the payload keeps its last value.
    always_comb begin
        vld_d  = vld_q;
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clr) begin
            vld_d = 1'b0;
        end else if (load) begin
            vld_d  = 1'b1;
            ctrl_d = d_ctrl;
            data_d = d_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign vld    = vld_q;
    assign q_ctrl = ctrl_q;
    assign q_data = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush. Define PIPE_STAGE_SKID_EN for the
// two-entry skid version (in_ready registered); otherwise a single entry is used.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    state_e            state_q, state_d;
    logic              init_q,  init_d;
    logic              push, pop;
    logic              ld0, clr0;
    logic              vld0;
    logic [CTRL_W-1:0] ctrl0, ctrl0_in;
    logic [DATA_W-1:0] data0, data0_in;

    assign push   = in_valid & in_ready;
    assign pop    = out_valid & out_ready;
    assign init_d = 1'b1;

    // init_q keeps in_ready low from reset until the first clock edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic              ld1, clr1, src_skid;
    logic              vld1;
    logic [CTRL_W-1:0] ctrl1;
    logic [DATA_W-1:0] data1;

    assign in_ready  = init_q && (state_q != ST_FULL);
    assign occupancy = {1'b0, vld0} + {1'b0, vld1};

    always_comb begin
        state_d  = state_q;
        ld0      = 1'b0;
        clr0     = 1'b0;
        ld1      = 1'b0;
        clr1     = 1'b0;
        src_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
            clr0    = 1'b1;
            clr1    = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: if (push) begin
                    ld0     = 1'b1;
                    state_d = ST_ONE;
                end
                ST_ONE: if (push && pop) begin
                    ld0 = 1'b1;
                end else if (push) begin
                    ld1     = 1'b1;
                    state_d = ST_FULL;
                end else if (pop) begin
                    clr0    = 1'b1;
                    state_d = ST_EMPTY;
                end
                ST_FULL: if (pop) begin
                    ld0      = 1'b1;
                    src_skid = 1'b1;
                    clr1     = 1'b1;
                    state_d  = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign ctrl0_in = src_skid ? ctrl1 : in_ctrl;
    assign data0_in = src_skid ? data1 : in_data;

    pipe_stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (ld1),
        .clr    (clr1),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .vld    (vld1),
        .q_ctrl (ctrl1),
        .q_data (data1)
    );
`else
    assign in_ready  = init_q && ((state_q == ST_EMPTY) || out_ready);
    assign occupancy = {1'b0, vld0};

    always_comb begin
        state_d = state_q;
        ld0     = 1'b0;
        clr0    = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
            clr0    = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: if (push) begin
                    ld0     = 1'b1;
                    state_d = ST_ONE;
                end
                ST_ONE: if (push) begin
                    ld0 = 1'b1;
                end else if (pop) begin
                    clr0    = 1'b1;
                    state_d = ST_EMPTY;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign ctrl0_in = in_ctrl;
    assign data0_in = in_data;
`endif

    pipe_stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_out (
        .clk    (clk),
        .reset  (reset),
        .load   (ld0),
        .clr    (clr0),
        .d_ctrl (ctrl0_in),
        .d_data (data0_in),
        .vld    (vld0),
        .q_ctrl (ctrl0),
        .q_data (data0)
    );

    // An empty stage presents a NOP on the control bits.
    assign out_valid = vld0;
    assign out_ctrl  = vld0 ? ctrl0 : '0;
    assign out_data  = data0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; follows PIPE_STAGE_SKID_EN to pick the stage capacity.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic [31:0] d;
        logic [7:0]  c;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_ctrl;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_ctrl;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    item_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic  armed;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Reference: the stage accepts only from the first clock edge after reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compares DUT status and every transferred output against the reference queue.
    always @(negedge clk) begin
        if (reset) begin
            check("occupancy", 32'(occupancy), 32'(exp_q.size()));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready),
                  32'(armed && ((CAP == 2) ? (exp_q.size() < 2) : (exp_q.size() == 0 || out_ready))));
            if (!out_valid) check("bubble_ctrl", 32'(out_ctrl), 32'h0);
            if (flush) begin
                exp_q.delete();
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_data), 32'hdead_beef);
                end else begin
                    item_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_ctrl", 32'(out_ctrl), 32'(e.c));
                end
            end
        end
    end

    // Drive one cycle of inputs; record the transfer the stage is expected to accept.
    task automatic cyc(input logic v, input logic [31:0] d, input logic [7:0] c,
                       input logic ordy, input logic fl);
        item_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #1;
        if (reset && !flush && in_valid && in_ready) begin
            e.d = in_data;
            e.c = in_ctrl;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        in_ctrl   = 8'hff;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_ctrl", 32'(out_ctrl), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_occupancy", 32'(occupancy), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_hold_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("pre_edge_in_ready", 32'(in_ready), 32'h0);

        // Single transfer: visible one cycle after the push.
        cyc(1'b1, 32'h0000_3000, 8'h05, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        check("first_out_data", out_data, 32'h0000_3000);
        check("first_out_ctrl", 32'(out_ctrl), 32'h05);
        check("first_occupancy", 32'(occupancy), 32'h1);
        repeat (2) cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Backpressure: stage fills to capacity and then drains in order.
        cyc(1'b1, 32'h11, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 8'h22, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        check("bp_occupancy", 32'(occupancy), 32'(CAP));
        check("bp_in_ready", 32'(in_ready), 32'h0);
        check("bp_hold_data", out_data, 32'h11);
        repeat (3) cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Streaming: one transfer per cycle with in_ready held high.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 32'(i), 8'(i + 1), 1'b1, 1'b0);
            check("stream_in_ready", 32'(in_ready), 32'h1);
        end
        repeat (2) cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Flush wins over a simultaneous push.
        cyc(1'b1, 32'hA0, 8'hA0, 1'b0, 1'b0);
        cyc(1'b1, 32'hA1, 8'hA1, 1'b0, 1'b0);
        cyc(1'b1, 32'hA2, 8'hA2, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        check("flush_occupancy", 32'(occupancy), 32'h0);
        check("flush_out_valid", 32'(out_valid), 32'h0);
        check("flush_out_ctrl", 32'(out_ctrl), 32'h0);
        check("flush_in_ready", 32'(in_ready), 32'h1);

        // Asynchronous reset in the middle of a cycle while holding entries.
        cyc(1'b1, 32'hB0, 8'hB0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB1, 8'hB1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        reset    = 1'b0;
        exp_q.delete();
        #1;
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_out_ctrl", 32'(out_ctrl), 32'h0);
        check("async_out_data", out_data, 32'h0);
        check("async_occupancy", 32'(occupancy), 32'h0);
        check("async_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, $urandom, 8'($urandom), ($urandom % 3) != 0,
                ($urandom % 25) == 0);
        end

        repeat (4) cyc(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        check("drain_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
